// File: rtl/network_pkg.sv
// Fixed-point format, helper arithmetic and shared types for the LSTM engine.
// All arithmetic is signed two's complement with FX_FRAC fractional bits.
package network_pkg;

   localparam int FX_INT  = 6;
   localparam int FX_FRAC = 11;
   localparam int FX_W    = FX_INT + FX_FRAC + 1;
   localparam int ACC_W   = FX_W + 8;
   localparam int FX_ONE  = 1 << FX_FRAC;

   typedef logic signed [FX_W-1:0]   word_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [2*FX_W-1:0] wide_t;

   typedef struct packed { word_t z; word_t i; word_t f; word_t o; } gates_t;
   typedef struct packed { acc_t  z; acc_t  i; acc_t  f; acc_t  o; } gate_acc_t;

   typedef enum logic [1:0] {IDLE, GATE, ELEM, DONE} state_t;

   localparam word_t ONE_W     = word_t'(FX_ONE);
   localparam word_t NEG_ONE_W = word_t'(-FX_ONE);
   localparam wide_t WMAX      = wide_t'((1 <<< (FX_W-1)) - 1);
   localparam wide_t WMIN      = -WMAX - wide_t'(1);

   function automatic word_t sat(input wide_t x);
      if (x > WMAX) return WMAX[FX_W-1:0];
      if (x < WMIN) return WMIN[FX_W-1:0];
      return x[FX_W-1:0];
   endfunction

   function automatic word_t fxmul(input word_t a, input word_t b);
      wide_t p;
      p = wide_t'(a) * wide_t'(b);
      return sat(p >>> FX_FRAC);
   endfunction

   function automatic word_t hsig(input word_t x);
      wide_t t;
      t = (wide_t'(x) >>> 2) + wide_t'(FX_ONE/2);
      if (t[2*FX_W-1]) return '0;
      if (t > wide_t'(FX_ONE)) return ONE_W;
      return t[FX_W-1:0];
   endfunction

   function automatic word_t htanh(input word_t x);
      if (x > ONE_W) return ONE_W;
      if (x < NEG_ONE_W) return NEG_ONE_W;
      return x;
   endfunction

endpackage

// File: rtl/weight_ram.sv
// Weight storage, one row per source element; combinational row read.
// Contents are loaded by hierarchical backdoor writes and survive reset.
module weight_ram #(
   parameter int ROWS      = 2,
   parameter int HIDDEN_SZ = 8,
   parameter int BITWIDTH  = 18,
   localparam int AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                          clock,
   input  logic [AW-1:0]                 addr,
   output logic [HIDDEN_SZ*BITWIDTH-1:0] row
);

   logic [HIDDEN_SZ*BITWIDTH-1:0] RAM_matrix [ROWS];

   // Pure storage: the array only changes through backdoor writes.
   always_ff @(posedge clock)
      for (int r = 0; r < ROWS; r++) RAM_matrix[r] <= RAM_matrix[r];

   assign row = RAM_matrix[addr];

endmodule

// File: rtl/network.sv
// Single-layer LSTM step: GATE (MAC per unit group), ELEM (c and h update), DONE.
// Result after (H/G)*(N+1) + 2*(H/M) + 1 cycles; newSample outside IDLE is dropped.
module network
   import network_pkg::*;
#(
   parameter int INPUT_SZ        = 2,
   parameter int HIDDEN_SZ       = 8,
   parameter int OUTPUT_SZ       = 1,
   parameter int QN              = 6,
   parameter int QM              = 11,
   parameter int DSP48_PER_ROW_G = 2,
   parameter int DSP48_PER_ROW_M = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [(QN+QM+1)*INPUT_SZ-1:0]     inputVec,
   input  logic                              clearState,
   input  logic                              newSample,
   output logic                              dataReady,
   output logic [(QN+QM+1)*OUTPUT_SZ-1:0]    outputVec
);

   localparam int BW  = QN + QM + 1;
   localparam int G   = DSP48_PER_ROW_G;
   localparam int M   = DSP48_PER_ROW_M;
   localparam int N   = INPUT_SZ + HIDDEN_SZ;
   localparam int NG  = HIDDEN_SZ / G;
   localparam int NM  = HIDDEN_SZ / M;
   localparam int KW  = $clog2(N + 1);
   localparam int GW  = $clog2(HIDDEN_SZ + 1);
   localparam int XAW = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1;
   localparam int YAW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
   localparam int RW  = HIDDEN_SZ * BW;

   state_t         state;
   logic [KW-1:0]  k;
   logic [GW-1:0]  grp;
   logic           phase;
   word_t          x_q [INPUT_SZ];
   word_t          c_q [HIDDEN_SZ];
   word_t          h_q [HIDDEN_SZ];
   gates_t         gate_q [HIDDEN_SZ];
   gate_acc_t      acc_q [G];
   logic [RW-1:0]  bZ, bI, bF, bO;

   logic [RW-1:0]  zx, ix, fx, ox, zy, iy, fy, oy;
   logic [RW-1:0]  wz, wi, wf, wo;
   logic [XAW-1:0] x_addr;
   logic [YAW-1:0] y_addr;
   logic           in_x;
   word_t          operand;
   gates_t         wsel [G];
   gates_t         bsel [G];
   gates_t         fin  [G];
   gates_t         eg   [M];
   word_t          ec   [M];
   word_t          c_new [M];
   word_t          h_new [M];

   assign in_x   = (k < KW'(INPUT_SZ));
   assign x_addr = XAW'(k);
   assign y_addr = YAW'(k - KW'(INPUT_SZ));

   weight_ram #(.ROWS(INPUT_SZ),  .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_Z_X (.clock(clock), .addr(x_addr), .row(zx));
   weight_ram #(.ROWS(INPUT_SZ),  .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_I_X (.clock(clock), .addr(x_addr), .row(ix));
   weight_ram #(.ROWS(INPUT_SZ),  .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_F_X (.clock(clock), .addr(x_addr), .row(fx));
   weight_ram #(.ROWS(INPUT_SZ),  .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_O_X (.clock(clock), .addr(x_addr), .row(ox));
   weight_ram #(.ROWS(HIDDEN_SZ), .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_Z_Y (.clock(clock), .addr(y_addr), .row(zy));
   weight_ram #(.ROWS(HIDDEN_SZ), .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_I_Y (.clock(clock), .addr(y_addr), .row(iy));
   weight_ram #(.ROWS(HIDDEN_SZ), .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_F_Y (.clock(clock), .addr(y_addr), .row(fy));
   weight_ram #(.ROWS(HIDDEN_SZ), .HIDDEN_SZ(HIDDEN_SZ), .BITWIDTH(BW)) WRAM_O_Y (.clock(clock), .addr(y_addr), .row(oy));

   assign wz = in_x ? zx : zy;
   assign wi = in_x ? ix : iy;
   assign wf = in_x ? fx : fy;
   assign wo = in_x ? ox : oy;

   // MAC operand: input elements first, then the previous hidden state.
   always_comb begin
      operand = '0;
      for (int n = 0; n < INPUT_SZ; n++)
         if (k == KW'(n)) operand = x_q[n];
      for (int n = 0; n < HIDDEN_SZ; n++)
         if (k == KW'(INPUT_SZ + n)) operand = h_q[n];
   end

   // Per-lane weight/bias/state selection for the active unit group.
   always_comb begin
      for (int u = 0; u < G; u++) begin
         wsel[u] = '0;
         bsel[u] = '0;
         for (int g = 0; g < NG; g++)
            if (grp == GW'(g)) begin
               wsel[u] = {wz[(g*G+u)*BW +: BW], wi[(g*G+u)*BW +: BW],
                          wf[(g*G+u)*BW +: BW], wo[(g*G+u)*BW +: BW]};
               bsel[u] = {bZ[(g*G+u)*BW +: BW], bI[(g*G+u)*BW +: BW],
                          bF[(g*G+u)*BW +: BW], bO[(g*G+u)*BW +: BW]};
            end
         fin[u].z = htanh(sat(wide_t'(acc_q[u].z) + wide_t'(bsel[u].z)));
         fin[u].i = hsig (sat(wide_t'(acc_q[u].i) + wide_t'(bsel[u].i)));
         fin[u].f = hsig (sat(wide_t'(acc_q[u].f) + wide_t'(bsel[u].f)));
         fin[u].o = hsig (sat(wide_t'(acc_q[u].o) + wide_t'(bsel[u].o)));
      end
      for (int u = 0; u < M; u++) begin
         eg[u] = '0;
         ec[u] = '0;
         for (int g = 0; g < NM; g++)
            if (grp == GW'(g)) begin
               eg[u] = gate_q[g*M+u];
               ec[u] = c_q[g*M+u];
            end
         c_new[u] = sat(wide_t'(fxmul(eg[u].f, ec[u])) + wide_t'(fxmul(eg[u].i, eg[u].z)));
         h_new[u] = fxmul(eg[u].o, htanh(ec[u]));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dataReady <= 1'b0;
         outputVec <= '0;
         k         <= '0;
         grp       <= '0;
         phase     <= 1'b0;
         bZ        <= '0;
         bI        <= '0;
         bF        <= '0;
         bO        <= '0;
         for (int n = 0; n < INPUT_SZ; n++) x_q[n] <= '0;
         for (int j = 0; j < HIDDEN_SZ; j++) begin
            c_q[j]    <= '0;
            h_q[j]    <= '0;
            gate_q[j] <= '0;
         end
         for (int u = 0; u < G; u++) acc_q[u] <= '0;
      end else begin
         case (state)
            IDLE: if (newSample) begin
               for (int n = 0; n < INPUT_SZ; n++) x_q[n] <= inputVec[n*BW +: BW];
               if (clearState)
                  for (int j = 0; j < HIDDEN_SZ; j++) begin
                     c_q[j] <= '0;
                     h_q[j] <= '0;
                  end
               for (int u = 0; u < G; u++) acc_q[u] <= '0;
               dataReady <= 1'b0;
               k         <= '0;
               grp       <= '0;
               state     <= GATE;
            end
            GATE: if (k != KW'(N)) begin
               for (int u = 0; u < G; u++) begin
                  acc_q[u].z <= acc_q[u].z + acc_t'(fxmul(operand, wsel[u].z));
                  acc_q[u].i <= acc_q[u].i + acc_t'(fxmul(operand, wsel[u].i));
                  acc_q[u].f <= acc_q[u].f + acc_t'(fxmul(operand, wsel[u].f));
                  acc_q[u].o <= acc_q[u].o + acc_t'(fxmul(operand, wsel[u].o));
               end
               k <= k + 1'b1;
            end else begin
               for (int j = 0; j < HIDDEN_SZ; j++)
                  if (grp == GW'(j / G)) gate_q[j] <= fin[j % G];
               for (int u = 0; u < G; u++) acc_q[u] <= '0;
               k <= '0;
               if (grp == GW'(NG - 1)) begin
                  grp   <= '0;
                  phase <= 1'b0;
                  state <= ELEM;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            ELEM: if (!phase) begin
               for (int j = 0; j < HIDDEN_SZ; j++)
                  if (grp == GW'(j / M)) c_q[j] <= c_new[j % M];
               phase <= 1'b1;
            end else begin
               for (int j = 0; j < HIDDEN_SZ; j++)
                  if (grp == GW'(j / M)) h_q[j] <= h_new[j % M];
               phase <= 1'b0;
               if (grp == GW'(NM - 1)) begin
                  grp   <= '0;
                  state <= DONE;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            DONE: begin
               for (int j = 0; j < OUTPUT_SZ; j++) outputVec[j*BW +: BW] <= h_q[j];
               dataReady <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network.sv
// Directed bench for the LSTM engine: hand-computed fixed-point results and latency.
module tb_network;

   logic        clock = 1'b0;
   logic        reset;
   logic [35:0] inputVec;
   logic        clearState;
   logic        newSample;
   logic        dataReady;
   logic [17:0] outputVec;

   int checks   = 0;
   int failures = 0;

   localparam logic [35:0] VEC_ONE0 = {18'd2048, 18'd0};

   network dut (
      .clock      (clock),
      .reset      (reset),
      .inputVec   (inputVec),
      .clearState (clearState),
      .newSample  (newSample),
      .dataReady  (dataReady),
      .outputVec  (outputVec)
   );

   always #5 clock = ~clock;

   task automatic clear_weights();
      for (int r = 0; r < 2; r++) begin
         dut.WRAM_Z_X.RAM_matrix[r] = '0;
         dut.WRAM_I_X.RAM_matrix[r] = '0;
         dut.WRAM_F_X.RAM_matrix[r] = '0;
         dut.WRAM_O_X.RAM_matrix[r] = '0;
      end
      for (int r = 0; r < 8; r++) begin
         dut.WRAM_Z_Y.RAM_matrix[r] = '0;
         dut.WRAM_I_Y.RAM_matrix[r] = '0;
         dut.WRAM_F_Y.RAM_matrix[r] = '0;
         dut.WRAM_O_Y.RAM_matrix[r] = '0;
      end
   endtask

   task automatic set_bias(input logic [17:0] z, input logic [17:0] i,
                           input logic [17:0] f, input logic [17:0] o);
      @(negedge clock);
      dut.bZ = {8{z}};
      dut.bI = {8{i}};
      dut.bF = {8{f}};
      dut.bO = {8{o}};
   endtask

   // lat counts edges after the accepting edge until dataReady is seen high.
   task automatic run_sample(input logic [35:0] vec, input logic clr, output int lat);
      @(negedge clock);
      inputVec   = vec;
      clearState = clr;
      newSample  = 1'b1;
      @(posedge clock);
      #1;
      newSample = 1'b0;
      lat = 0;
      while (!dataReady && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      newSample  = 1'b0;
      clearState = 1'b0;
      inputVec   = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (dataReady !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 0", dataReady);
      end
      checks++;
      if (outputVec !== 18'd0) begin
         failures++;
         $display("FAIL reset_out: got %h expected 0", outputVec);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_zero();
      int lat;
      clear_weights();
      set_bias('0, '0, '0, '0);
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (lat !== 53) begin
         failures++;
         $display("FAIL zero_latency: got %0d expected 53", lat);
      end
      checks++;
      if (outputVec !== 18'd0) begin
         failures++;
         $display("FAIL zero_out: got %h expected 0", outputVec);
      end
   endtask

   task automatic test_bias_state();
      int lat;
      set_bias(18'd2048, 18'd2048, 18'd0, 18'd2048);
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (lat !== 53) begin
         failures++;
         $display("FAIL bias_latency: got %0d expected 53", lat);
      end
      checks++;
      if (outputVec !== 18'd1152) begin
         failures++;
         $display("FAIL bias_out: got %0d expected 1152", outputVec);
      end
      run_sample(VEC_ONE0, 1'b0, lat);
      checks++;
      if (outputVec !== 18'd1536) begin
         failures++;
         $display("FAIL carry_out: got %0d expected 1536", outputVec);
      end
      checks++;
      if (dut.c_q[0] !== 18'd2304) begin
         failures++;
         $display("FAIL carry_cell: got %0d expected 2304", dut.c_q[0]);
      end
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (outputVec !== 18'd1152) begin
         failures++;
         $display("FAIL clear_out: got %0d expected 1152", outputVec);
      end
   endtask

   task automatic test_weight();
      int lat;
      set_bias('0, '0, '0, '0);
      dut.WRAM_Z_X.RAM_matrix[1] = {8{18'd2048}};
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (outputVec !== 18'd512) begin
         failures++;
         $display("FAIL weight_out: got %0d expected 512", outputVec);
      end
      @(negedge clock);
      dut.WRAM_Z_X.RAM_matrix[1] = '0;
   endtask

   task automatic test_saturate();
      int lat;
      logic [17:0] neg4096;
      neg4096 = -18'sd4096;
      set_bias(neg4096, 18'd8192, 18'd0, 18'd8192);
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (outputVec !== 18'h3F800) begin
         failures++;
         $display("FAIL saturate_out: got %h expected 3f800", outputVec);
      end
   endtask

   task automatic test_busy_ignored();
      int lat;
      bit stable;
      set_bias(18'd2048, 18'd2048, 18'd0, 18'd2048);
      @(negedge clock);
      inputVec   = VEC_ONE0;
      clearState = 1'b1;
      newSample  = 1'b1;
      @(posedge clock);
      #1;
      newSample = 1'b0;
      lat = 0;
      while (!dataReady && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
         if (lat == 10 || lat == 50) begin
            newSample  = 1'b1;
            inputVec   = {18'd0, 18'd4096};
            clearState = 1'b0;
         end else begin
            newSample = 1'b0;
         end
      end
      newSample = 1'b0;
      checks++;
      if (lat !== 53) begin
         failures++;
         $display("FAIL busy_latency: got %0d expected 53", lat);
      end
      checks++;
      if (outputVec !== 18'd1152) begin
         failures++;
         $display("FAIL busy_out: got %0d expected 1152", outputVec);
      end
      stable = 1'b1;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (dataReady !== 1'b1 || outputVec !== 18'd1152) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL hold_result: got ready=%b out=%0d expected ready=1 out=1152", dataReady, outputVec);
      end
   endtask

   task automatic test_abort();
      int lat;
      set_bias(18'd2048, 18'd2048, 18'd0, 18'd2048);
      dut.WRAM_O_Y.RAM_matrix[3] = {8{18'd777}};
      @(negedge clock);
      inputVec   = VEC_ONE0;
      clearState = 1'b1;
      newSample  = 1'b1;
      @(posedge clock);
      #1;
      newSample = 1'b0;
      repeat (15) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (dataReady !== 1'b0) begin
         failures++;
         $display("FAIL abort_ready: got %b expected 0", dataReady);
      end
      checks++;
      if (outputVec !== 18'd0) begin
         failures++;
         $display("FAIL abort_out: got %0d expected 0", outputVec);
      end
      checks++;
      if (dut.bZ !== 144'd0) begin
         failures++;
         $display("FAIL abort_bias: got %h expected 0", dut.bZ);
      end
      checks++;
      if (dut.WRAM_O_Y.RAM_matrix[3] !== {8{18'd777}}) begin
         failures++;
         $display("FAIL abort_ram: got %h expected %h", dut.WRAM_O_Y.RAM_matrix[3], {8{18'd777}});
      end
      clear_weights();
      @(negedge clock);
      reset = 1'b1;
      run_sample(VEC_ONE0, 1'b1, lat);
      checks++;
      if (lat !== 53) begin
         failures++;
         $display("FAIL abort_latency: got %0d expected 53", lat);
      end
      checks++;
      if (outputVec !== 18'd0) begin
         failures++;
         $display("FAIL abort_result: got %0d expected 0", outputVec);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_bias_state();
      test_weight();
      test_saturate();
      test_busy_ignored();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
